// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: opcodes, ALU pin encodings,
// sequencer states and the command FIFO entry.
package alu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned IN_SEL_W  = 3;
  localparam int unsigned OUT_SEL_W = 7;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6,
    OP_CLR  = 3'd7
  } aluOpT;

  localparam logic [IN_SEL_W-1:0] SEL_PERSIST = 3'b001;
  localparam logic [IN_SEL_W-1:0] SEL_LOAD    = 3'b010;
  localparam logic [IN_SEL_W-1:0] SEL_RESET   = 3'b100;

  localparam logic [OUT_SEL_W-1:0] OUT_AND  = 7'b0000001;
  localparam logic [OUT_SEL_W-1:0] OUT_OR   = 7'b0000010;
  localparam logic [OUT_SEL_W-1:0] OUT_NOT  = 7'b0000100;
  localparam logic [OUT_SEL_W-1:0] OUT_XOR  = 7'b0001000;
  localparam logic [OUT_SEL_W-1:0] OUT_ADD  = 7'b0010000;
  localparam logic [OUT_SEL_W-1:0] OUT_SUB  = 7'b0100000;
  localparam logic [OUT_SEL_W-1:0] OUT_MULT = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seqStateT;

  typedef struct packed {
    aluOpT             op;
    logic              chain;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmdEntryT;

  // CLR drives the AND selector; every other opcode maps to its own one-hot bit.
  function automatic logic [OUT_SEL_W-1:0] outSelFor(aluOpT op);
    return (op == OP_CLR) ? OUT_AND : (OUT_SEL_W'(1) << op);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  cmdEntryT         pushData,
  input  logic             pop,
  output cmdEntryT         popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  cmdEntryT         mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countNext;
  logic             doPush;
  logic             doPop;

  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + CNT_W'(1);
    end else if (doPop && !doPush) begin
      countNext = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= countNext;
      full  <= (countNext == CNT_W'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: queues commands, drives the ALU pins,
// waits out its register latency and presents the result on a valid/ready port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic                 cmd_chain,
  input  logic [DATA_W-1:0]    cmd_a,
  input  logic [DATA_W-1:0]    cmd_b,
  output logic [DATA_W-1:0]    alu_num1,
  output logic [DATA_W-1:0]    alu_num2,
  output logic [IN_SEL_W-1:0]  alu_in_sel,
  output logic [OUT_SEL_W-1:0] alu_out_sel,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_ovf,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_ovf,
  output logic [OP_W-1:0]      res_op,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned LAT_W = $clog2(ALU_LAT + 1);

  seqStateT          state;
  logic [LAT_W-1:0]  waitCnt;
  logic [DATA_W-1:0] acc;
  aluOpT             curOp;
  cmdEntryT          pushEntry;
  cmdEntryT          head;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              doPush;
  logic              doPop;

  assign pushEntry = '{op: aluOpT'(cmd_op), chain: cmd_chain, a: cmd_a, b: cmd_b};
  assign doPush    = cmd_valid && !fifoFull;
  assign doPop     = (state == ST_IDLE) && !fifoEmpty;
  assign cmd_ready = !fifoFull;

  alu_cmd_fifo #(.DEPTH(DEPTH)) cmdFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .pushData (pushEntry),
    .pop      (doPop),
    .popData  (head),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Sequencer FSM; ALU drive registers only change on a pop so they hold in IDLE/HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      waitCnt     <= '0;
      acc         <= '0;
      curOp       <= OP_AND;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_in_sel  <= SEL_RESET;
      alu_out_sel <= OUT_AND;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_op      <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (doPop) begin
            state <= ST_ISSUE;
            busy  <= 1'b1;
            curOp <= head.op;
            if (head.op == OP_CLR) begin
              alu_in_sel  <= SEL_RESET;
              alu_out_sel <= OUT_AND;
              alu_num1    <= '0;
              alu_num2    <= '0;
            end else begin
              alu_in_sel  <= SEL_LOAD;
              alu_out_sel <= outSelFor(head.op);
              alu_num1    <= head.chain ? acc : head.a;
              alu_num2    <= head.b;
            end
          end else begin
            busy <= doPush;
          end
        end
        ST_ISSUE: begin
          state   <= ST_WAIT;
          waitCnt <= LAT_W'(ALU_LAT);
        end
        ST_WAIT: begin
          if (waitCnt == LAT_W'(1)) begin
            state     <= ST_HOLD;
            res_valid <= 1'b1;
            res_op    <= curOp;
            if (curOp == OP_CLR) begin
              res_data <= '0;
              res_ovf  <= 1'b0;
              acc      <= '0;
            end else begin
              res_data <= alu_result;
              res_ovf  <= (curOp == OP_MULT) && alu_ovf;
              acc      <= alu_result;
            end
          end else begin
            waitCnt <= waitCnt - LAT_W'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= (fifoCount != '0) || doPush;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end placed directly upstream of the 8-bit ALU top. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. For each command it drives the ALU's operand, input-selector and output-selector pins, waits out the ALU's register latency, and captures the ALU result and overflow into a valid/ready result port. An internal accumulator lets a command chain on the previous result.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2
- ALU_LAT, 1: cycles from the ALU operand-register capture edge to a stable ALU result
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous assert, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full
- cmd_op  input  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLR
- cmd_chain  input  1  use the accumulator instead of cmd_a as operand A
- cmd_a, cmd_b  input  8  operands A and B
- alu_num1, alu_num2  output  8  ALU operands
- alu_in_sel  output  3  one-hot: bit0 persist, bit1 load, bit2 reset
- alu_out_sel  output  7  one-hot: bit0 AND … bit6 MULT, in cmd_op order
- alu_result  input  8  ALU output value
- alu_ovf  input  1  ALU multiply overflow
- res_valid  output  1  result available
- res_ready  input  1  result consumer accepts
- res_data  output  8  captured result
- res_ovf  output  1  captured overflow
- res_op  output  3  opcode that produced the result
- busy  output  1  state is not IDLE, or FIFO is not empty

## Operation
- FIFO entry is {op, chain, a, b}. A push happens on cmd_valid && cmd_ready. cmd_ready = !full, so there is no same-cycle bypass when full.
- Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop at this edge, load the ALU drive registers, and go to ISSUE.
  - ISSUE: one cycle with the ALU inputs stable. Go to WAIT and load wait_cnt = ALU_LAT.
  - WAIT: decrement wait_cnt. When it reaches 1, at that edge capture res_data = alu_result, set res_op, set res_valid = 1, and go to HOLD.
  - HOLD: when res_ready is high, clear res_valid at that edge and go to IDLE.
- ALU drive per op:
  - ops 0–6: alu_in_sel = load; alu_out_sel = onehot(op); alu_num1 = chain ? acc : a; alu_num2 = b.
  - CLR: alu_in_sel = reset; alu_out_sel = AND; both operands 0. It clears acc and produces res_data = 0x00 and res_ovf = 0, without sampling alu_result.
- res_ovf = alu_ovf for MULT, otherwise 0. ADD carry and SUB borrow are discarded; results are modulo 256.
- acc is updated to res_data at each capture edge.
- In IDLE and HOLD the ALU drive registers hold their last values. They do not toggle.
- The NOT op ignores operand B, but B is still driven.

## Timing
- Reset values:
  - state IDLE; FIFO empty; acc 0x00
  - cmd_ready 1; res_valid 0; res_data 0x00; res_ovf 0; res_op 0; busy 0
  - alu_in_sel 3'b100; alu_out_sel 7'b0000001; alu_num1 and alu_num2 0x00
- All outputs are registered.
- Latency: command accepted at edge E; res_valid rises after edge E+2+ALU_LAT (3 cycles at the default).
- Throughput: one command per ALU_LAT+3 cycles, with res_ready held high.
- res_data, res_ovf and res_op are stable while res_valid is high.
- Reset asserted mid-operation clears the FIFO, acc, the FSM and res_valid immediately. In-flight and queued commands are dropped.
- Reset deassertion is synchronized externally.

## Structure
- Shared package alu_pkg holds:
  - opcode constants
  - one-hot in_sel constants (SEL_PERSIST, SEL_LOAD, SEL_RESET) and out_sel constants
  - the state enum
- Sub-module alu_cmd_fifo: DEPTH-entry synchronous FIFO with full, empty and count outputs.
- The FSM, drive registers, accumulator and result registers live in the top.

## Test plan
- ADD, a=0x0F, b=0x01, res_ready=1 -> res_data 0x10, res_ovf 0, res_valid exactly 3 cycles after accept.
- MULT, a=0x10, b=0x10 -> res_ovf 1, res_data equals the ALU's low byte (0x00); alu_out_sel 7'b1000000 during ISSUE.
- ADD a=3, b=4, then SUB with chain=1 and b=2 -> results 0x07 then 0x05; alu_num1 = 0x07 during the second ISSUE.
- res_ready=0, push 6 commands back-to-back -> 5 accepted (1 in HOLD, 4 queued); cmd_ready low on the 6th. Raising res_ready drains all 5 in order.
- Push ADD 1+1, then CLR, then chained ADD b=5 -> results 0x02, 0x00, 0x05; alu_in_sel 3'b100 during the CLR ISSUE.
- Assert rst during WAIT with 2 commands queued -> outputs return to reset values within the same cycle. After release, no result appears and busy stays 0.
